// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: D-cache miss stall with timeout, branch flush and load-use stall.
// Optional performance counters are compiled in when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int unsigned MISS_TIMEOUT = 256,
   parameter int unsigned REG_WIDTH    = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_d,
   input  logic [REG_WIDTH-1:0] rs1_d,
   input  logic [REG_WIDTH-1:0] rs2_d,
   input  logic                 valid_e,
   input  logic [REG_WIDTH-1:0] rd_e,
   input  logic                 mem_read_e,
   input  logic                 branch_taken_e,
   input  logic                 valid_m,
   input  logic                 mem_req_m,
   input  logic                 cache_ready_m,
   output logic                 pc_en,
   output logic                 fd_en,
   output logic                 de_en,
   output logic                 em_en,
   output logic                 mw_en,
   output logic                 fd_flush_n,
   output logic                 de_flush_n,
   output logic                 em_flush_n,
   output logic                 mw_flush_n,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_count,
   output logic [31:0]          miss_count,
`endif
   output logic                 miss_err
);

   localparam int unsigned CntW = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MISS_TIMEOUT - 1);

   typedef enum logic [1:0] {StRun, StMiss, StErr} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic miss_now;
   logic load_use;
   logic branch;
   logic branch_flush;
   logic run_to_miss;

   assign miss_now = valid_m & mem_req_m & ~cache_ready_m;
   assign branch   = valid_e & branch_taken_e;
   assign load_use = valid_e & mem_read_e & (rd_e != '0) & valid_d &
                     ((rd_e == rs1_d) | (rd_e == rs2_d));

   // State and miss-cycle counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and stall/flush decode; priority is ERR > miss > branch > load-use
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_en        = 1'b1;
      fd_en        = 1'b1;
      de_en        = 1'b1;
      em_en        = 1'b1;
      mw_en        = 1'b1;
      fd_flush_n   = 1'b1;
      de_flush_n   = 1'b1;
      em_flush_n   = 1'b1;
      mw_flush_n   = 1'b1;
      miss_err     = 1'b0;
      branch_flush = 1'b0;
      run_to_miss  = 1'b0;
      if (!rst_n) begin
         pc_en      = 1'b0;
         fd_en      = 1'b0;
         de_en      = 1'b0;
         em_en      = 1'b0;
         mw_en      = 1'b0;
         fd_flush_n = 1'b0;
         de_flush_n = 1'b0;
         em_flush_n = 1'b0;
         mw_flush_n = 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (miss_now) begin
                  pc_en       = 1'b0;
                  fd_en       = 1'b0;
                  de_en       = 1'b0;
                  em_en       = 1'b0;
                  mw_en       = 1'b0;
                  mw_flush_n  = 1'b0;
                  state_d     = StMiss;
                  cnt_d       = '0;
                  run_to_miss = 1'b1;
               end else if (branch) begin
                  // Wrong-path D instruction is flushed, so any load-use on it is moot
                  fd_flush_n   = 1'b0;
                  de_flush_n   = 1'b0;
                  branch_flush = 1'b1;
               end else if (load_use) begin
                  pc_en      = 1'b0;
                  fd_en      = 1'b0;
                  de_flush_n = 1'b0;
               end
            end
            StMiss: begin
               if (cache_ready_m) begin
                  // Release cycle: everything advances; a frozen branch is seen next RUN cycle
                  state_d = StRun;
                  cnt_d   = '0;
               end else begin
                  pc_en      = 1'b0;
                  fd_en      = 1'b0;
                  de_en      = 1'b0;
                  em_en      = 1'b0;
                  mw_en      = 1'b0;
                  mw_flush_n = 1'b0;
                  if (cnt_q == CntLast) begin
                     state_d = StErr;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StErr: begin
               pc_en      = 1'b0;
               fd_en      = 1'b0;
               de_en      = 1'b0;
               em_en      = 1'b0;
               mw_en      = 1'b0;
               fd_flush_n = 1'b0;
               de_flush_n = 1'b0;
               em_flush_n = 1'b0;
               mw_flush_n = 1'b0;
               miss_err   = 1'b1;
            end
            default: begin
               state_d = StRun;
               cnt_d   = '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q, flush_count_q, miss_count_q;

   // Free-running wrap-around performance counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
         miss_count_q   <= '0;
      end else begin
         if (!pc_en && (state_q != StErr)) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (branch_flush)                 flush_count_q  <= flush_count_q + 32'd1;
         if (run_to_miss)                  miss_count_q   <= miss_count_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
   assign miss_count   = miss_count_q;
`else
   logic unused_flags;
   assign unused_flags = branch_flush ^ run_to_miss;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MISS_TIMEOUT, default 256, max cycles a D-cache miss stalls before error.
REQ-002 SHALL have parameter REG_WIDTH, default 5, register-index width.
REQ-003 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- valid_d  in  1  D-stage instruction valid.
- rs1_d, rs2_d  in  REG_WIDTH  D-stage source registers.
- valid_e  in  1  E-stage instruction valid.
- rd_e  in  REG_WIDTH  E-stage destination.
- mem_read_e  in  1  E-stage instruction is a load.
- branch_taken_e  in  1  E-stage branch/jump redirect.
- valid_m  in  1  M-stage instruction valid.
- mem_req_m  in  1  M-stage load/store accessing D-cache.
- cache_ready_m  in  1  D-cache hit or fill complete this cycle.
- pc_en  out  1  PC update enable.
- fd_en, de_en, em_en, mw_en  out  1  pipeline register enables (low = stall).
- fd_flush_n, de_flush_n, em_flush_n, mw_flush_n  out  1  pipeline register flushes (active-low).
- miss_err  out  1  sticky miss-timeout error.

Function
REQ-004 SHALL implement FSM states RUN, MISS, ERR; all outputs are combinational from state and inputs.
REQ-005 Miss detect: in RUN, valid_m & mem_req_m & !cache_ready_m SHALL drive all en low, mw_flush_n low, and next state MISS.
REQ-006 In MISS, while !cache_ready_m: all en low, mw_flush_n low, other flush_n high; miss counter increments each cycle.
REQ-007 In MISS, cache_ready_m high SHALL make all en high, all flush_n high, next state RUN, and clear the miss counter, all in the same cycle.
REQ-008 If the miss counter reaches MISS_TIMEOUT-1 while in MISS with !cache_ready_m, next state SHALL be ERR.
REQ-009 In ERR: all en low, all flush_n low, miss_err high; exit only by reset.
REQ-010 Load-use: valid_e & mem_read_e & rd_e!=0 & valid_d & (rd_e==rs1_d | rd_e==rs2_d) in RUN with no miss SHALL drive pc_en=0, fd_en=0, de_flush_n=0, and all other en/flush_n high.
REQ-011 Branch: branch_taken_e & valid_e in RUN with no miss SHALL drive fd_flush_n=0 and de_flush_n=0, with all en high.
REQ-012 Priority SHALL be ERR > miss (REQ-005/006) > branch > load-use.
- Branch with load-use in the same cycle: branch response only, because the D instruction is wrong-path.
REQ-013 A branch arriving during a miss SHALL be frozen in E and acted on in the first RUN cycle after release.
REQ-014 With no hazard in RUN, all en and flush_n SHALL be high.
REQ-015 rd_e==0 SHALL never cause a load-use stall; invalid D or E instructions SHALL never cause stall or flush.

Reset
REQ-016 When rst_n is low at a clock edge: state RUN, miss counter 0, miss_err 0, perf counters 0.
REQ-017 While rst_n is low, outputs SHALL be: all en low, all flush_n low, pc_en low.
REQ-018 Reset mid-MISS or in ERR SHALL abandon the miss; the first cycle after release is RUN.

Configuration
REQ-019 Macro HAZARD_PERF_CNT_EN defined SHALL add three outputs, each 32-bit, wrapping at 2^32:
- stall_cycles: +1 per cycle with pc_en low, outside reset and ERR.
- flush_count: +1 per branch flush.
- miss_count: +1 per RUN->MISS transition.
REQ-020 Macro HAZARD_PERF_CNT_EN undefined SHALL remove these ports and their logic; all other behaviour is identical.

Verification
REQ-021 Bench SHALL cover:
- Load-use: rd_e=5, mem_read_e=1, rs1_d=5 -> one cycle with pc_en=0, fd_en=0, de_flush_n=0, then all high.
- Miss: mem_req_m=1, cache_ready_m=0 for 10 cycles, then 1 -> 10 cycles with all en=0 and mw_flush_n=0; release cycle all high; state RUN.
- Timeout: MISS_TIMEOUT=8, cache_ready_m held 0 -> ERR after 8 miss cycles, miss_err=1 and stays 1 until rst_n=0.
- Branch with load-use: branch_taken_e=1 and load-use both true -> fd_flush_n=0, de_flush_n=0, pc_en=1.
- Reset mid-miss: rst_n=0 at miss cycle 3 -> outputs at reset values; after release, RUN and miss_err=0.
- HAZARD_PERF_CNT_EN: 2 misses of 4 cycles each plus 1 load-use -> miss_count=2, stall_cycles=9.
